// File: rtl/umi_arbiter_sched.sv
// Output-port scheduler for the UMI switch: one-hot grant with hold/lock across back-pressure and multi-beat packets.
// Optional starvation promotion is compiled in with `define UMI_ARB_STARVE_EN.

`ifdef UMI_ARB_STARVE_EN
module umi_arb_starve_cnt #(
  parameter int SCW = 4
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           req,
  input  logic           mask,
  input  logic           mine,
  input  logic           eom_xfer,
  output logic [SCW-1:0] cnt
);
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                       cnt <= '0;
    else if (!req || (eom_xfer && mine)) cnt <= '0;
    else if (eom_xfer && !mask && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule
`endif

module umi_arbiter_sched #(
  parameter int N             = 4,
  parameter int STARVE_THRESH = 15,
  parameter int SCW           = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [1:0]   arbmode,
  input  logic [N-1:0] arbmask,
  input  logic [N-1:0] req,
  input  logic [N-1:0] req_eom,
  input  logic         out_ready,
  output logic [N-1:0] grant,
  output logic         out_valid,
  output logic [N-1:0] in_ready,
  output logic         locked
);
  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {ARB, HOLD, LOCK} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d, elig, arb_gnt, sel;
  logic [PW-1:0]   ptr_q, ptr_d, rr_idx, gidx;
  logic            found, xfer, eom, rr_mode;

  assign elig    = req & ~arbmask;
  assign rr_mode = (arbmode[1] == arbmode[0]);

`ifdef UMI_ARB_STARVE_EN
  logic [N-1:0][SCW-1:0] starve_cnt;
  logic [N-1:0]          starving;

  for (genvar i = 0; i < N; i++) begin : g_starve
    umi_arb_starve_cnt #(.SCW(SCW)) u_cnt (
      .clk      (clk),
      .nreset   (nreset),
      .req      (req[i]),
      .mask     (arbmask[i]),
      .mine     (sel[i]),
      .eom_xfer (xfer & eom),
      .cnt      (starve_cnt[i])
    );
    assign starving[i] = elig[i] && (starve_cnt[i] >= SCW'(STARVE_THRESH));
  end
`else
  logic [SCW-1:0] unused_thresh;
  assign unused_thresh = SCW'(STARVE_THRESH);
`endif

  // Starved requesters (lowest index) pre-empt whatever arbmode would pick.
  always_comb begin
    arb_gnt = '0;
    rr_idx  = '0;
    found   = 1'b0;
`ifdef UMI_ARB_STARVE_EN
    for (int i = 0; i < N; i++)
      if (!found && starving[i]) begin
        arb_gnt[i] = 1'b1;
        found      = 1'b1;
      end
`endif
    case (arbmode)
      2'b01: begin
        for (int i = 0; i < N; i++)
          if (!found && elig[i]) begin
            arb_gnt[i] = 1'b1;
            found      = 1'b1;
          end
      end
      2'b10: begin
        for (int i = N - 1; i >= 0; i--)
          if (!found && elig[i]) begin
            arb_gnt[i] = 1'b1;
            found      = 1'b1;
          end
      end
      default: begin
        for (int i = 0; i < N; i++) begin
          rr_idx = PW'((int'(ptr_q) + i) % N);
          if (!found && elig[rr_idx]) begin
            arb_gnt[rr_idx] = 1'b1;
            found           = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    if (!nreset)           sel = '0;
    else if (state_q == ARB) sel = arb_gnt;
    else                   sel = gnt_q;
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++)
      if (sel[i]) gidx = PW'(i);
  end

  assign grant     = sel;
  assign out_valid = |(req & sel);
  assign in_ready  = sel & {N{out_ready}};
  assign locked    = (state_q == LOCK);
  assign xfer      = out_valid & out_ready;
  assign eom       = |(req_eom & sel);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    if (xfer && eom && rr_mode)
      ptr_d = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    case (state_q)
      ARB: begin
        gnt_d = arb_gnt;
        if (xfer && !eom)               state_d = LOCK;
        else if (out_valid && !out_ready) state_d = HOLD;
      end
      HOLD: if (xfer) state_d = eom ? ARB : LOCK;
      LOCK: if (xfer && eom) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ARB;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_umi_arbiter_sched.sv
// Randomized bench for umi_arbiter_sched against an owner/pointer reference model, plus directed scenarios.
module tb_umi_arbiter_sched;
  localparam int N  = 4;
  localparam int TH = 2;
  localparam int SW = 4;

  logic         clk = 1'b0;
  logic         nreset;
  logic [1:0]   arbmode;
  logic [N-1:0] arbmask, req, req_eom;
  logic         out_ready;
  logic [N-1:0] grant, in_ready;
  logic         out_valid, locked;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: who owns the output (-1 = free), whether mid-packet, RR pointer, starvation counts
  int m_owner = -1;
  bit m_lk    = 0;
  int m_ptr   = 0;
  int m_cnt [N];

  umi_arbiter_sched #(.N(N), .STARVE_THRESH(TH), .SCW(SW)) dut (
    .clk(clk), .nreset(nreset), .arbmode(arbmode), .arbmask(arbmask),
    .req(req), .req_eom(req_eom), .out_ready(out_ready),
    .grant(grant), .out_valid(out_valid), .in_ready(in_ready), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input logic [N-1:0] mk, input logic [1:0] md);
    logic [N-1:0] e;
    e = r & ~mk;
    if (e == '0) return -1;
`ifdef UMI_ARB_STARVE_EN
    for (int i = 0; i < N; i++) if (e[i] && m_cnt[i] >= TH) return i;
`endif
    if (md == 2'b01) begin
      for (int i = 0; i < N; i++) if (e[i]) return i;
    end else if (md == 2'b10) begin
      for (int i = N - 1; i >= 0; i--) if (e[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (e[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One cycle: drive on negedge, check just after, advance model for the coming posedge.
  task automatic cyc(input logic rn, input logic [1:0] md, input logic [N-1:0] mk,
                     input logic [N-1:0] r, input logic [N-1:0] e, input logic rd);
    int g;
    bit v, x, eo;
    logic [N-1:0] eg;
    @(negedge clk);
    nreset = rn; arbmode = md; arbmask = mk; req = r; req_eom = e; out_ready = rd;
    #1;
    g  = !rn ? -1 : (m_owner >= 0 ? m_owner : pick(r, mk, md));
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    v  = (g >= 0) && r[g];
    x  = v && rd;
    eo = (g >= 0) && e[g];
    check("grant",     int'(grant),     int'(eg));
    check("out_valid", int'(out_valid), int'(v));
    check("in_ready",  int'(in_ready),  rd ? int'(eg) : 0);
    check("locked",    int'(locked),    int'(rn && m_owner >= 0 && m_lk));
    if (!rn) begin
      m_owner = -1; m_lk = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (!r[i] || (x && eo && g == i)) m_cnt[i] = 0;
        else if (x && eo && !mk[i] && m_cnt[i] < (1 << SW) - 1) m_cnt[i]++;
      if (x && eo && md[1] == md[0]) m_ptr = (g + 1) % N;
      if (m_owner < 0) begin
        if (x && !eo)      begin m_owner = g; m_lk = 1; end
        else if (v && !rd) begin m_owner = g; m_lk = 0; end
      end else if (x) begin
        if (eo) begin m_owner = -1; m_lk = 0; end
        else m_lk = 1;
      end
    end
  endtask

  initial begin
    logic [3:0] exp_rr [5];
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    nreset = 1'b0; arbmode = '0; arbmask = '0; req = '0; req_eom = '0; out_ready = 1'b0;

    // reset with requests present: everything quiet
    cyc(1'b0, 2'b00, 4'h0, 4'hf, 4'hf, 1'b1);
    check("rst_grant", int'(grant), 0);
    cyc(1'b0, 2'b00, 4'h0, 4'hf, 4'hf, 1'b1);

    // round-robin fairness with single-beat traffic
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 2'b00, 4'h0, 4'hf, 4'hf, 1'b1);
      check("rr_seq", int'(grant), int'(exp_rr[k]));
    end

    // back-pressure: grant holds until ready, then the other requester wins
    for (int k = 0; k < 3; k++) cyc(1'b1, 2'b10, 4'h0, 4'b0001, 4'hf, 1'b0);
    cyc(1'b1, 2'b10, 4'h0, 4'b0011, 4'hf, 1'b0);
    check("bp_hold", int'(grant), 1);
    cyc(1'b1, 2'b10, 4'h0, 4'b0011, 4'hf, 1'b1);
    check("bp_xfer", int'(grant), 1);
    cyc(1'b1, 2'b10, 4'h0, 4'b0011, 4'hf, 1'b1);
    check("bp_next", int'(grant), 2);

    // three-beat packet with a bubble on req0
    cyc(1'b1, 2'b01, 4'h0, 4'hf, 4'h0, 1'b1);
    cyc(1'b1, 2'b01, 4'h0, 4'hf, 4'h0, 1'b1);
    check("lk_b2_locked", int'(locked), 1);
    cyc(1'b1, 2'b01, 4'h0, 4'b1110, 4'h0, 1'b1);
    check("lk_gap_grant", int'(grant), 1);
    check("lk_gap_inrdy", int'(in_ready), 1);
    cyc(1'b1, 2'b01, 4'h0, 4'hf, 4'b0001, 1'b1);
    check("lk_b3_locked", int'(locked), 1);
    cyc(1'b1, 2'b01, 4'h0, 4'hf, 4'hf, 1'b1);
    check("lk_after", int'(locked), 0);

    // mask in arbitration, ignored while locked
    cyc(1'b1, 2'b01, 4'b0001, 4'b0011, 4'h0, 1'b1);
    check("mask_arb", int'(grant), 2);
    cyc(1'b1, 2'b01, 4'b0010, 4'b0011, 4'h0, 1'b1);
    check("mask_lock", int'(grant), 2);
    cyc(1'b1, 2'b01, 4'b0010, 4'b0011, 4'hf, 1'b1);
    cyc(1'b1, 2'b01, 4'b0010, 4'b0011, 4'hf, 1'b1);
    check("mask_release", int'(grant), 1);

    // reset in the middle of a locked packet
    cyc(1'b1, 2'b00, 4'h0, 4'b0001, 4'h0, 1'b1);
    cyc(1'b0, 2'b00, 4'h0, 4'b0001, 4'h0, 1'b1);
    check("rst_mid_valid", int'(out_valid), 0);
    cyc(1'b1, 2'b00, 4'h0, 4'b1000, 4'hf, 1'b1);
    check("rst_rel_grant", int'(grant), 8);
    check("rst_rel_locked", int'(locked), 0);

    // starvation promotion (fixed-low priority otherwise always favours req0)
    cyc(1'b0, 2'b01, 4'h0, 4'h0, 4'h0, 1'b1);
    cyc(1'b1, 2'b01, 4'h0, 4'b1001, 4'hf, 1'b1);
    cyc(1'b1, 2'b01, 4'h0, 4'b1001, 4'hf, 1'b1);
    cyc(1'b1, 2'b01, 4'h0, 4'b1001, 4'hf, 1'b1);
`ifdef UMI_ARB_STARVE_EN
    check("starve", int'(grant), 8);
`else
    check("starve", int'(grant), 1);
`endif

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [1:0]   md;
      logic [N-1:0] mk, r, e;
      md = 2'($urandom);
      mk = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      r  = N'($urandom) | N'($urandom);
      e  = N'($urandom);
      cyc(($urandom_range(0, 99) != 0), md, mk, r, e, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
